serial_prog_receiver: RTL and testbench

//  Chip-side receiver for the gain-programming serial link driven by the FPGA model (o_sclk/o_sdout).

---
 rtl/serial_prog_receiver.sv | 162 ++++++++++++++++
 tb/tb_serial_prog_receiver.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_prog_receiver.sv
// Gain-programming serial receiver: oversamples sclk/sdin, shifts in one LSB-first frame,
// then latches both gain codes and raises o_ready. Optional abort timer: `define SPROG_TIMEOUT_EN.
module serial_prog_receiver #(
   parameter int GAIN1_W        = 2,
   parameter int GAIN2_W        = 3,
   parameter int GAINA1_DEFAULT = 0,
   parameter int GAINA2_DEFAULT = 0,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               i_mainclk,
   input  logic               i_resetAll,
   input  logic               i_sclk,
   input  logic               i_sdin,
   output logic [GAIN1_W-1:0] o_gainA1,
   output logic [GAIN2_W-1:0] o_gainA2,
   output logic               o_ready,
   output logic               o_busy,
   output logic               o_frame_err
);

   localparam int NBITS = GAIN1_W + GAIN2_W;
   localparam int CNT_W = $clog2(NBITS + 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic               sclk_s1_q, sclk_s2_q, sclk_prev_q;
   logic               sdin_s1_q, sdin_s2_q;
   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
   logic [NBITS-1:0]   word_q, word_d, word_cap;
   logic [GAIN1_W-1:0] gain1_q, gain1_d;
   logic [GAIN2_W-1:0] gain2_q, gain2_d;
   logic               ready_q, ready_d;
   logic               sclk_rise, sclk_fall;

   assign sclk_rise = sclk_s2_q & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s2_q & sclk_prev_q;

   // Synchronizers reset to the idle line levels so release of reset never fakes an edge.
   always_ff @(posedge i_mainclk or posedge i_resetAll) begin
      if (i_resetAll) begin
         sclk_s1_q   <= 1'b1;
         sclk_s2_q   <= 1'b1;
         sclk_prev_q <= 1'b1;
         sdin_s1_q   <= 1'b0;
         sdin_s2_q   <= 1'b0;
      end else begin
         sclk_s1_q   <= i_sclk;
         sclk_s2_q   <= sclk_s1_q;
         sclk_prev_q <= sclk_s2_q;
         sdin_s1_q   <= i_sdin;
         sdin_s2_q   <= sdin_s1_q;
      end
   end

`ifdef SPROG_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
   logic            frame_err_q, frame_err_d;
   logic            timeout_hit;

   always_comb begin
      idle_cnt_d  = '0;
      timeout_hit = 1'b0;
      if (state_q == ST_SHIFT && !(sclk_rise || sclk_fall)) begin
         if (idle_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end
      frame_err_d = timeout_hit;
   end

   always_ff @(posedge i_mainclk or posedge i_resetAll) begin
      if (i_resetAll) begin
         idle_cnt_q  <= '0;
         frame_err_q <= 1'b0;
      end else begin
         idle_cnt_q  <= idle_cnt_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign o_frame_err = frame_err_q;
`else
   logic timeout_hit;
   assign timeout_hit = 1'b0;
   assign o_frame_err = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      bitcnt_d = bitcnt_q;
      word_d   = word_q;
      gain1_d  = gain1_q;
      gain2_d  = gain2_q;
      ready_d  = ready_q;
      word_cap = word_q;
      word_cap[bitcnt_q] = sdin_s2_q;
      case (state_q)
         ST_IDLE: begin
            if (sclk_fall) begin
               state_d  = ST_SHIFT;
               bitcnt_d = '0;
               word_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (sclk_rise) begin
               word_d = word_cap;
               // Gains take the whole word, including the bit landing this cycle.
               if (bitcnt_q == CNT_W'(NBITS - 1)) begin
                  state_d = ST_DONE;
                  gain1_d = word_cap[GAIN1_W-1:0];
                  gain2_d = word_cap[NBITS-1:GAIN1_W];
                  ready_d = 1'b1;
               end else begin
                  bitcnt_d = bitcnt_q + 1'b1;
               end
            end else if (timeout_hit) begin
               state_d  = ST_IDLE;
               bitcnt_d = '0;
               word_d   = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_mainclk or posedge i_resetAll) begin
      if (i_resetAll) begin
         state_q  <= ST_IDLE;
         bitcnt_q <= '0;
         word_q   <= '0;
         gain1_q  <= GAIN1_W'(GAINA1_DEFAULT);
         gain2_q  <= GAIN2_W'(GAINA2_DEFAULT);
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitcnt_q <= bitcnt_d;
         word_q   <= word_d;
         gain1_q  <= gain1_d;
         gain2_q  <= gain2_d;
         ready_q  <= ready_d;
      end
   end

   assign o_gainA1 = gain1_q;
   assign o_gainA2 = gain2_q;
   assign o_ready  = ready_q;
   assign o_busy   = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_serial_prog_receiver.sv
// Scoreboard bench for serial_prog_receiver: stimulus pushes expected gains and ready time,
// a negedge monitor pops on each o_ready rise and also watches frozen/partial-update rules.
module tb_serial_prog_receiver;

   localparam int D1 = 0;
   localparam int D2 = 0;

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk;
   logic       sdin;
   logic [1:0] gain_a1;
   logic [2:0] gain_a2;
   logic       ready;
   logic       busy;
   logic       frame_err;

   serial_prog_receiver dut (
      .i_mainclk   (clk),
      .i_resetAll  (rst),
      .i_sclk      (sclk),
      .i_sdin      (sdin),
      .o_gainA1    (gain_a1),
      .o_gainA2    (gain_a2),
      .o_ready     (ready),
      .o_busy      (busy),
      .o_frame_err (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int g1;
      int g2;
      int due;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_total = 0;
   int   n_pass = 0;
   int   partial_viol = 0;
   int   sticky_viol = 0;
   int   fe_cnt = 0;
   int   fe_expected = 0;
   bit   model_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Model: a frame is the 5 bits sent; gains are plain weighted sums of those bits.
   task automatic send_bits(input logic [4:0] b, input int first, input int last, input int hp);
      exp_t e;
      for (int i = first; i <= last; i++) begin
         @(posedge clk); #1;
         sclk = 1'b0;
         sdin = b[i];
         repeat (hp) @(posedge clk);
         #1;
         sclk = 1'b1;
         if (i == 4 && !model_done) begin
            e.g1 = int'(b[0]) + 2 * int'(b[1]);
            e.g2 = int'(b[2]) + 2 * int'(b[3]) + 4 * int'(b[4]);
            e.due = cyc + 3;
            q.push_back(e);
            model_done = 1'b1;
         end
         repeat (hp) @(posedge clk);
      end
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk); #3;
      rst  = 1'b1;
      sclk = 1'b1;
      sdin = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk({tag, "_rst_gainA1"}, int'(gain_a1), D1);
      chk({tag, "_rst_gainA2"}, int'(gain_a2), D2);
      chk({tag, "_rst_ready"}, int'(ready), 0);
      chk({tag, "_rst_busy"}, int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      model_done = 1'b0;
   endtask

   logic       prev_ready = 1'b0;
   logic [1:0] prev_g1 = '0;
   logic [2:0] prev_g2 = '0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_ready = 1'b0;
      end else begin
         if (!ready && (int'(gain_a1) != D1 || int'(gain_a2) != D2)) partial_viol++;
         if (prev_ready && !ready) sticky_viol++;
         if (prev_ready && ready && (gain_a1 != prev_g1 || gain_a2 != prev_g2)) sticky_viol++;
         if (frame_err) fe_cnt++;
         if (!prev_ready && ready) begin
            if (q.size() == 0) begin
               chk("unexpected_ready", 1, 0);
            end else begin
               e = q.pop_front();
               chk("sb_gainA1", int'(gain_a1), e.g1);
               chk("sb_gainA2", int'(gain_a2), e.g2);
               chk("sb_ready_cycle", cyc, e.due);
               chk("sb_busy_after_done", int'(busy), 0);
            end
         end
         prev_ready = ready;
         prev_g1    = gain_a1;
         prev_g2    = gain_a2;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] b;
      int         hp;
      int         k;
      int         fe0;
      rst  = 1'b1;
      sclk = 1'b1;
      sdin = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("init_gainA1", int'(gain_a1), D1);
      chk("init_gainA2", int'(gain_a2), D2);
      chk("init_ready", int'(ready), 0);
      chk("init_busy", int'(busy), 0);
      chk("init_frame_err", int'(frame_err), 0);
      @(negedge clk);
      rst = 1'b0;

      // Random sdin chatter while sclk idles high must not start a frame.
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         sdin = 1'($urandom);
      end
      repeat (4) @(posedge clk);
      #1;
      chk("idle_noise_busy", int'(busy), 0);
      chk("idle_noise_ready", int'(ready), 0);
      chk("idle_noise_gainA1", int'(gain_a1), D1);
      chk("idle_noise_gainA2", int'(gain_a2), D2);

      send_bits(5'b11111, 0, 4, 16);

      do_reset("t2");
      send_bits(5'b10110, 0, 3, 16);
      #1;
      chk("t2_partial_gainA1", int'(gain_a1), D1);
      chk("t2_partial_gainA2", int'(gain_a2), D2);
      chk("t2_partial_busy", int'(busy), 1);
      send_bits(5'b10110, 4, 4, 16);

      send_bits(5'b00000, 0, 3, 16);
      #1;
      chk("t3_frozen_gainA1", int'(gain_a1), 2);
      chk("t3_frozen_gainA2", int'(gain_a2), 5);
      chk("t3_frozen_ready", int'(ready), 1);
      chk("t3_frozen_busy", int'(busy), 0);

      do_reset("t4a");
      send_bits(5'b00101, 0, 2, 16);
      do_reset("t4b");
      send_bits(5'b11001, 0, 4, 16);

`ifdef SPROG_TIMEOUT_EN
      do_reset("t5");
      fe0 = fe_cnt;
      send_bits(5'b00011, 0, 1, 16);
      repeat (100) @(posedge clk);
      #1;
      chk("t5_frame_err_pulses", fe_cnt - fe0, 1);
      chk("t5_busy", int'(busy), 0);
      chk("t5_ready", int'(ready), 0);
      fe_expected = fe_expected + 1;
      send_bits(5'b00011, 0, 4, 16);
`endif

      for (int it = 0; it < 10; it++) begin
         do_reset("rnd");
         b  = 5'($urandom);
         hp = $urandom_range(3, 16);
         if ($urandom_range(0, 3) == 0) begin
            k = $urandom_range(0, 4);
            if (k > 0) send_bits(b, 0, k - 1, hp);
            do_reset("rnd_abort");
            b  = 5'($urandom);
         end
         send_bits(b, 0, 4, hp);
      end

      for (int i = 0; i < 200 && q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      chk("queue_drained", q.size(), 0);
      chk("no_partial_update", partial_viol, 0);
      chk("ready_sticky_gains_frozen", sticky_viol, 0);
      chk("frame_err_count", fe_cnt, fe_expected);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
